// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop input synchronizer, free-running oversample tick,
// and a four-state framing FSM with registered rx_done / framing_error pulses.
module uart_receiver #(
  parameter int DATA_SIZE    = 8,
  parameter int BAUD_DIVISOR = 651,
  parameter int OVERSAMPLE   = 16
) (
  input  logic                 clk_100MHz,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_SIZE-1:0] rx_data,
  output logic                 rx_done,
  output logic                 framing_error,
  output logic                 busy
);

  localparam int TW = (BAUD_DIVISOR > 1) ? $clog2(BAUD_DIVISOR) : 1;
  localparam int SW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int NW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(BAUD_DIVISOR - 1);
  localparam logic [SW-1:0] S_MID     = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);
  localparam logic [NW-1:0] N_LAST    = NW'(DATA_SIZE - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic                 rx_meta_q, rx_sync_q;
  logic [TW-1:0]        tick_cnt_q;
  logic                 tick;

  state_t               state_q, state_d;
  logic [SW-1:0]        s_q, s_d;
  logic [NW-1:0]        n_q, n_d;
  logic [DATA_SIZE-1:0] shreg_q, shreg_d;
  logic [DATA_SIZE-1:0] rx_data_q, rx_data_d;
  logic                 rx_done_q, rx_done_d;
  logic                 ferr_q, ferr_d;

  assign tick = (tick_cnt_q == TICK_LAST);

  // Synchronizer resets to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk_100MHz) begin
    if (!reset) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      tick_cnt_q <= '0;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (!reset) begin
      state_q   <= IDLE;
      s_q       <= '0;
      n_q       <= '0;
      shreg_q   <= '0;
      rx_data_q <= '0;
      rx_done_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      shreg_q   <= shreg_d;
      rx_data_q <= rx_data_d;
      rx_done_q <= rx_done_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    n_d       = n_q;
    shreg_d   = shreg_q;
    rx_data_d = rx_data_q;
    rx_done_d = 1'b0;
    ferr_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Start detection is not tick-aligned, bounding start uncertainty to one tick.
        if (!rx_sync_q) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (tick) begin
          if (s_q == S_MID) begin
            s_d = '0;
            if (!rx_sync_q) begin
              state_d = DATA;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_q == S_LAST) begin
            s_d     = '0;
            shreg_d = {rx_sync_q, shreg_q[DATA_SIZE-1:1]};
            if (n_q == N_LAST) state_d = STOP;
            else               n_d     = n_q + 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s_q == S_LAST) begin
            state_d = IDLE;
            s_d     = '0;
            if (rx_sync_q) begin
              rx_data_d = shreg_q;
              rx_done_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_data       = rx_data_q;
  assign rx_done       = rx_done_q;
  assign framing_error = ferr_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboarded bench for uart_receiver: frames are generated from the 8N1 rules,
// expected outcomes queued at send time and matched by an independent monitor.
module tb_uart_receiver;
  localparam int BD  = 4;
  localparam int OS  = 16;
  localparam int BIT = BD * OS;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done, framing_error, busy;

  always #5 clk = ~clk;

  uart_receiver #(.DATA_SIZE(8), .BAUD_DIVISOR(BD), .OVERSAMPLE(OS)) dut (
    .clk_100MHz   (clk),
    .reset        (reset),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_done      (rx_done),
    .framing_error(framing_error),
    .busy         (busy)
  );

  typedef struct {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  int         tests = 0;
  int         fails = 0;
  logic [7:0] last_good = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  // Expected outcome: good stop -> the byte; low stop -> framing error, word unchanged.
  task automatic send_frame(input logic [7:0] d, input logic stop_ok,
                            input int gl_bit, input int gl_off);
    exp_t e;
    if (stop_ok) begin
      e.is_err = 1'b0; e.data = d; last_good = d;
    end else begin
      e.is_err = 1'b1; e.data = last_good;
    end
    exp_q.push_back(e);
    $display("[TB] send frame %02h stop_ok=%0b glitch_bit=%0d", d, stop_ok, gl_bit);
    hold(1'b0, BIT);
    for (int i = 0; i < 8; i++) begin
      if (i == gl_bit) begin
        hold(d[i], gl_off);
        hold(~d[i], 1);
        hold(d[i], BIT - gl_off - 1);
      end else begin
        hold(d[i], BIT);
      end
    end
    if (stop_ok) begin
      hold(1'b1, BIT);
    end else begin
      hold(1'b0, 40);
      hold(1'b1, 2 * BIT - 40);
    end
    rx = 1'b1;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 4000) begin
      @(negedge clk);
      k++;
    end
    check(name, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rx_done || framing_error) begin
      exp_t e;
      check("pulse_exclusive", {31'b0, rx_done & framing_error}, 0);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: got done=%0b ferr=%0b data=%02h expected no pulse",
                 rx_done, framing_error, rx_data);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", {31'b0, framing_error}, {31'b0, e.is_err});
        check("rx_data", {24'b0, rx_data}, {24'b0, e.data});
        $display("[TB] pulse done=%0b ferr=%0b data=%02h", rx_done, framing_error, rx_data);
      end
    end
  end

  initial begin
    logic [7:0] d7e;
    logic [7:0] d;
    logic       ok;
    int         gb, go, gap;
    d7e = 8'h7E;

    repeat (3) @(negedge clk);
    check("reset_rx_data", {24'b0, rx_data}, 0);
    check("reset_done", {31'b0, rx_done}, 0);
    check("reset_ferr", {31'b0, framing_error}, 0);
    check("reset_busy", {31'b0, busy}, 0);
    reset = 1'b1;
    hold(1'b1, 20);

    send_frame(8'h41, 1'b1, -1, 0);
    hold(1'b1, BIT);
    check("busy_after_41", {31'b0, busy}, 0);
    drain("drain_41");

    hold(1'b0, 20);
    check("busy_in_start", {31'b0, busy}, 1);
    hold(1'b1, BIT);
    check("busy_after_glitch", {31'b0, busy}, 0);
    check("data_after_glitch", {24'b0, rx_data}, {24'b0, last_good});

    send_frame(8'h55, 1'b0, -1, 0);
    drain("drain_55");

    send_frame(8'h53, 1'b1, -1, 0);
    send_frame(8'h49, 1'b1, -1, 0);
    hold(1'b1, BIT);
    drain("drain_b2b");

    hold(1'b0, BIT);
    for (int i = 0; i < 3; i++) hold(d7e[i], BIT);
    hold(d7e[3], 20);
    reset = 1'b0;
    @(negedge clk);
    check("midreset_rx_data", {24'b0, rx_data}, 0);
    check("midreset_busy", {31'b0, busy}, 0);
    @(negedge clk);
    reset = 1'b1;
    rx = 1'b1;
    last_good = 8'h00;
    hold(1'b1, 2 * BIT);
    send_frame(8'h4F, 1'b1, -1, 0);
    hold(1'b1, BIT);
    drain("drain_4f");

    send_frame(8'hA5, 1'b1, 3, 10);
    hold(1'b1, BIT);
    drain("drain_a5");

    for (int it = 0; it < 30; it++) begin
      d   = 8'($urandom);
      ok  = ($urandom_range(0, 3) != 0);
      gb  = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : -1;
      go  = int'($urandom_range(2, 20));
      gap = ($urandom_range(0, 1) != 0) ? 0 : int'($urandom_range(1, 100));
      if (gap > 0) hold(1'b1, gap);
      send_frame(d, ok, gb, go);
    end
    hold(1'b1, BIT);
    drain("drain_random");
    check("busy_final", {31'b0, busy}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter DATA_SIZE, default 8: number of data bits per frame; matches the FIFO data word.
REQ-002 Parameter BAUD_DIVISOR, default 651: clk_100MHz cycles per oversample tick (100 MHz / (9600 x 16)).
REQ-003 Parameter OVERSAMPLE, default 16: ticks per bit period.
REQ-004 clk_100MHz  input  1  system clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset: sampled only at the clk_100MHz rising edge, asserted when 0.
REQ-006 rx  input  1  asynchronous serial line, idle high, 8N1 framing, LSB first.
REQ-007 rx_data  output  DATA_SIZE  last correctly framed data word; held until the next good frame.
REQ-008 rx_done  output  1  one-cycle pulse marking rx_data valid; drives the FIFO write_to_fifo input directly.
REQ-009 framing_error  output  1  one-cycle pulse when the stop bit samples low.
REQ-010 busy  output  1  high whenever the state is not IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer before use; rx_sync is the second flop.
REQ-012 The tick counter SHALL free-run 0..BAUD_DIVISOR-1 and wrap to 0; tick is high for one cycle when the count equals BAUD_DIVISOR-1.
REQ-013 The FSM SHALL have four states: IDLE, START, DATA and STOP. It also SHALL hold a sample counter s (0..OVERSAMPLE-1), a bit counter n (0..DATA_SIZE-1) and a shift register shreg (DATA_SIZE bits).
REQ-014 IDLE: rx_sync==0 SHALL move the FSM to START with s=0, on any cycle and without waiting for a tick.
REQ-015 START, on tick with s==OVERSAMPLE/2-1: if rx_sync==0, move to DATA with s=0 and n=0; otherwise return to IDLE as a glitch, with no outputs pulsed.
REQ-016 START, on tick with s below that value: s SHALL increment by 1.
REQ-017 DATA, on tick with s==OVERSAMPLE-1: s=0 and shreg={rx_sync, shreg[DATA_SIZE-1:1]}. If n==DATA_SIZE-1, move to STOP; otherwise increment n.
REQ-018 DATA, on tick with other s: s SHALL increment by 1.
REQ-019 STOP, on tick with s==OVERSAMPLE-1: return to IDLE with s=0.
 - If rx_sync==1: rx_data<=shreg and rx_done=1 in the next cycle.
 - If rx_sync==0: framing_error=1 in the next cycle, and rx_data is unchanged.
REQ-020 STOP, on tick with other s: s SHALL increment by 1.
REQ-021 rx_done and framing_error SHALL be registered, high for exactly one clk_100MHz cycle, and never high together.
REQ-022 On a non-tick cycle, START, DATA and STOP SHALL hold s, n and shreg unchanged.
REQ-023 A falling edge on rx while busy==1 SHALL NOT restart the frame; it is only acted on in IDLE.
REQ-024 Back-to-back frames, with the next start bit beginning immediately after the stop bit, SHALL be received without loss.
REQ-025 Frame start sampling uncertainty SHALL be at most one tick period; no handshake exists; a downstream FIFO full condition SHALL NOT stall reception.

Reset
REQ-026 With reset==0 at a clock edge, the outputs SHALL take these values at that edge:
 - state=IDLE; s=0, n=0, shreg=0.
 - tick counter=0.
 - both synchronizer flops=1.
 - rx_data=0, rx_done=0, framing_error=0, busy=0.
REQ-027 Reset mid-frame SHALL abandon the frame without pulsing rx_done or framing_error. The first start bit seen after reset releases SHALL be received normally.

Verification (BAUD_DIVISOR=4, OVERSAMPLE=16, so one bit = 64 cycles)
REQ-028 Frame 0x41 (bits 0,1000 0010,1) -> exactly one rx_done pulse with rx_data=0x41, busy low afterwards, and framing_error never high.
REQ-029 rx low for 20 cycles, then high -> return to IDLE by START's mid-bit sample, no rx_done, no framing_error, and rx_data unchanged.
REQ-030 Frame 0x55 with the stop bit driven low -> one framing_error pulse, no rx_done, and rx_data keeps its prior value.
REQ-031 Frames 0x53 then 0x49 sent back-to-back with no idle gap -> two rx_done pulses with rx_data=0x53 then 0x49.
REQ-032 reset driven low for 2 cycles during the fourth data bit of 0x7E, then a clean frame 0x4F -> no pulse for the aborted frame, and one rx_done with rx_data=0x4F.
REQ-033 A glitch of 1 cycle low on rx while busy in DATA -> the frame is unaffected if the glitch misses the sample point, and the data word is correct.
